// File: rtl/fan_pkg.sv
// Shared configuration and state encoding for the reduction-tree result collector.
package fan_pkg;

  localparam int N       = 32;
  localparam int DW_DATA = 8;
  localparam int N_SLOTS = 2 * (N - 1);
  localparam int IDX_W   = $clog2(N_SLOTS);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/fan_prio_enc.sv
// Lowest-set-bit priority encoder: reports the index of the lowest set mask bit.
module fan_prio_enc
  import fan_pkg::*;
#(
  parameter int W  = N_SLOTS,
  parameter int IW = IDX_W
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          found
);

  // NOTE: both outputs get a default before the loop so no latch is inferred.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan high to low so the lowest set bit is the last write and wins.
    for (int k = W - 1; k >= 0; k--) begin
      if (mask[k]) begin
        idx   = IW'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fan_collector.sv
// Serialises a masked reduction-tree output vector into one result per cycle.
// Optional FAN_COLLECT_PERF_EN adds emitted-result and stall-cycle counters.
module fan_collector #(
  parameter  int N       = fan_pkg::N,
  parameter  int DW_DATA = fan_pkg::DW_DATA,
  localparam int N_SLOTS = 2 * (N - 1),
  localparam int IDX_W   = $clog2(N_SLOTS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW_DATA*N_SLOTS-1:0] in_data,
  input  logic [N_SLOTS-1:0]         in_mask,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW_DATA-1:0]         out_data,
  output logic [IDX_W-1:0]           out_idx,
`ifdef FAN_COLLECT_PERF_EN
  output logic                       out_last,
  output logic [31:0]                perf_emit_cnt,
  output logic [31:0]                perf_stall_cnt
`else
  output logic                       out_last
`endif
);

  import fan_pkg::*;

  state_t                     state, state_next;
  logic [DW_DATA*N_SLOTS-1:0] buf_data;
  logic [N_SLOTS-1:0]         buf_mask, mask_next;
  logic                       buf_last;
  logic [IDX_W-1:0]           head_idx;
  logic                       head_found;
  logic                       one_left;
  logic                       accept;
  logic                       pop;

  fan_prio_enc #(
    .W  (N_SLOTS),
    .IW (IDX_W)
  ) u_prio_enc (
    .mask  (buf_mask),
    .idx   (head_idx),
    .found (head_found)
  );

  // Clearing the lowest bit leaves zero exactly when a single bit remains.
  assign one_left = head_found && ((buf_mask & (buf_mask - N_SLOTS'(1))) == '0);

  assign out_valid = !rst && (state == DRAIN);
  assign in_ready  = !rst && ((state == IDLE) || (one_left && out_ready));
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_idx  = out_valid ? head_idx : '0;
  assign out_data = out_valid ? buf_data[int'(head_idx)*DW_DATA +: DW_DATA] : '0;
  assign out_last = out_valid && buf_last && one_left;

  always_comb begin
    state_next = state;
    mask_next  = buf_mask;
    if (accept) begin
      // Also covers the final pop overlapping a new acceptance.
      mask_next  = in_mask;
      state_next = (in_mask != '0) ? DRAIN : IDLE;
    end else if (pop) begin
      mask_next = buf_mask & ~(N_SLOTS'(1) << head_idx);
      if (one_left) state_next = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      buf_mask <= '0;
      buf_last <= 1'b0;
    end else begin
      state    <= state_next;
      buf_mask <= mask_next;
      if (accept) buf_last <= in_last;
    end
  end

  // NOTE: the data buffer is not reset; the cleared mask makes stale contents unobservable.
  always_ff @(posedge clk) begin
    if (accept) buf_data <= in_data;
  end

`ifdef FAN_COLLECT_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_emit_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop)                     perf_emit_cnt  <= perf_emit_cnt + 32'd1;
      if (out_valid && !out_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fan_collector.sv
// Directed, scoreboard-checked bench for fan_collector (default N=32, DW_DATA=8).
module tb_fan_collector;

  localparam int NS = 62;
  localparam int DW = 8;
  localparam int IW = 6;

  typedef struct {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [DW*NS-1:0] in_data;
  logic [NS-1:0]    in_mask;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last;
`ifdef FAN_COLLECT_PERF_EN
  logic [31:0]      perf_emit_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  fan_collector #(
    .N       (32),
    .DW_DATA (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_mask        (in_mask),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_idx        (out_idx),
`ifdef FAN_COLLECT_PERF_EN
    .out_last       (out_last),
    .perf_emit_cnt  (perf_emit_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`else
    .out_last       (out_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one expected result per set mask bit, lowest index first.
  task automatic push_expected(input logic [NS-1:0] mask, input logic last, input logic [DW*NS-1:0] data);
    int   hi;
    exp_t e;
    hi = -1;
    for (int k = 0; k < NS; k++) if (mask[k]) hi = k;
    for (int k = 0; k < NS; k++) begin
      if (mask[k]) begin
        e.idx  = IW'(k);
        e.data = data[k*DW +: DW];
        e.last = last && (k == hi);
        sb.push_back(e);
      end
    end
  endtask

  // Offer a vector with random slot data; returns after the accepting edge.
  task automatic offer(input logic [NS-1:0] mask, input logic last, output int waited);
    logic accepted;
    for (int k = 0; k < NS; k++) in_data[k*DW +: DW] = DW'($urandom);
    in_mask  = mask;
    in_last  = last;
    in_valid = 1'b1;
    accepted = 1'b0;
    waited   = 0;
    for (int c = 0; c < 20 && !accepted; c++) begin
      @(negedge clk);
      if (in_ready) begin
        push_expected(mask, last, in_data);
        accepted = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) check("accept_timeout", 64'(accepted), 64'd1);
  endtask

  // Scoreboard consumer: every output handshake must match the queue head.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        check("out_idx", 64'(out_idx), 64'(sb[0].idx));
        check("out_data", 64'(out_data), 64'(sb[0].data));
        check("out_last", 64'(out_last), 64'(sb[0].last));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int            waited;
    int            seen;
    logic [DW-1:0] slot0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Mask 0x5 with last: idx 0 then idx 2 on consecutive cycles, last only on idx 2.
    @(posedge clk);
    #1;
    offer(NS'(62'h5), 1'b1, waited);
    @(negedge clk);
    check("m5_first_valid", 64'(out_valid), 64'd1);
    check("m5_first_idx", 64'(out_idx), 64'd0);
    check("m5_first_last", 64'(out_last), 64'd0);
    @(negedge clk);
    check("m5_second_valid", 64'(out_valid), 64'd1);
    check("m5_second_idx", 64'(out_idx), 64'd2);
    check("m5_second_last", 64'(out_last), 64'd1);
    @(negedge clk);
    check("m5_done_valid", 64'(out_valid), 64'd0);

    // Back-to-back masks 0x1 and 0x2 with no bubble.
    @(posedge clk);
    #1;
    offer(NS'(62'h1), 1'b0, waited);
    offer(NS'(62'h2), 1'b1, waited);
    check("b2b_no_wait", 64'(waited), 64'd0);
    @(negedge clk);
    check("b2b_second_valid", 64'(out_valid), 64'd1);
    check("b2b_second_idx", 64'(out_idx), 64'd1);
    @(negedge clk);
    check("b2b_done_valid", 64'(out_valid), 64'd0);

    // Fresh reset so the optional counters start from zero, then a 3-cycle stall on mask 0x3.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b0;
    offer(NS'(62'h3), 1'b0, waited);
    slot0 = in_data[DW-1:0];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_idx", 64'(out_idx), 64'd0);
      check("stall_data", 64'(out_data), 64'(slot0));
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stall_done_valid", 64'(out_valid), 64'd0);
`ifdef FAN_COLLECT_PERF_EN
    check("perf_stall_cnt", 64'(perf_stall_cnt), 64'd3);
    check("perf_emit_cnt", 64'(perf_emit_cnt), 64'd2);
`endif

    // Zero mask with last: accepted at once, nothing emitted.
    @(posedge clk);
    #1;
    offer('0, 1'b1, waited);
    check("zero_accept_wait", 64'(waited), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("zero_no_valid", 64'(out_valid), 64'd0);
      check("zero_in_ready", 64'(in_ready), 64'd1);
    end

    // All-ones mask, reset after 10 pops discards the remainder.
    @(posedge clk);
    #1;
    offer('1, 1'b1, waited);
    seen = 0;
    for (int c = 0; c < 20 && seen < 10; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("pops_before_rst", 64'(seen), 64'd10);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_drain_valid", 64'(out_valid), 64'd0);
    check("rst_mid_drain_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_release_in_ready", 64'(in_ready), 64'd1);
    check("rst_release_valid", 64'(out_valid), 64'd0);

    // A vector after the reset must produce only its own result.
    @(posedge clk);
    #1;
    offer(NS'(62'h10), 1'b1, waited);
    for (int c = 0; c < 200 && sb.size() != 0; c++) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    @(negedge clk);
    check("final_idle_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fan_collector.md
FAN_COLLECTOR -- requirements
Module: fan_collector

Interface
REQ-001 SHALL have parameter N, default 32, meaning the number of reduction-tree leaves.
REQ-002 SHALL have parameter DW_DATA, default 8, meaning the width of one result element.
REQ-003 SHALL derive N_SLOTS = 2*(N-1) and IDX_W = $clog2(N_SLOTS); with the defaults these are 62 and 6.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit: the tree output vector is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the collector accepts a vector this cycle.
REQ-008 SHALL have port in_data, input, DW_DATA*N_SLOTS bits: the tree output bus; slot k occupies bits [k*DW_DATA +: DW_DATA].
REQ-009 SHALL have port in_mask, input, N_SLOTS bits: bit k set means slot k holds a finished sum.
REQ-010 SHALL have port in_last, input, 1 bit: the vector closes a tile.
REQ-011 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 SHALL have port out_data, output, DW_DATA bits: the selected slot value.
REQ-014 SHALL have port out_idx, output, IDX_W bits: the source slot index.
REQ-015 SHALL have port out_last, output, 1 bit: the final result of a vector whose in_last was set.

Function
REQ-016 SHALL accept a vector when in_valid && in_ready, latching in_data, in_mask and in_last into a holding buffer.
REQ-017 SHALL implement two states: IDLE and DRAIN.
- IDLE -> DRAIN on acceptance with a nonzero mask.
- An accepted zero mask stays in IDLE and emits nothing, including when in_last is set.
REQ-018 SHALL, in DRAIN, present the lowest-indexed set bit of the remaining mask: out_data = that slot, out_idx = its index, out_valid = 1.
REQ-019 SHALL clear the presented bit on out_valid && out_ready and hold out_data, out_idx and out_last stable while out_valid && !out_ready.
REQ-020 SHALL assert out_last only with the last remaining set bit of a vector latched with in_last = 1.
REQ-021 SHALL drive in_ready = 1 in IDLE, and in DRAIN only when exactly one mask bit remains and out_ready = 1, so vectors stream back-to-back with no bubble.
REQ-022 SHALL, on a simultaneous final pop and new acceptance, load the new vector and go to DRAIN if its mask is nonzero, else IDLE.
REQ-023 SHALL present the first result the cycle after acceptance (latency 1) and sustain one result per cycle while out_ready = 1.
REQ-024 SHALL pass data unmodified, with no arithmetic on the data.

Reset
REQ-025 SHALL, while rst = 1, set state = IDLE, buffer mask = 0, out_valid = 0, out_last = 0, out_data = 0, out_idx = 0, in_ready = 0.
REQ-026 SHALL drive in_ready = 1 from the first cycle after rst deasserts.
REQ-027 SHALL, on rst asserted mid-DRAIN, discard remaining results with no partial output afterwards.

Configuration
REQ-028 SHALL support macro FAN_COLLECT_PERF_EN; when defined, add outputs perf_emit_cnt (32 bits, counts out handshakes) and perf_stall_cnt (32 bits, counts cycles with out_valid && !out_ready).
REQ-029 SHALL make both counters wrap at 2^32 and clear on rst.
REQ-030 SHALL, without FAN_COLLECT_PERF_EN, have neither counter ports nor counter logic.

Structure
REQ-031 SHALL take N, DW_DATA, N_SLOTS, IDX_W and the state enum from shared package fan_pkg.
REQ-032 SHALL place lowest-set-bit detection (mask in; index and found flag out) in sub-module fan_prio_enc.

Verification
REQ-033 SHALL cover this directed case: mask = 0x5 (slots 0 and 2), in_last = 1, out_ready held high -> results idx 0 then idx 2 on consecutive cycles, out_last only on idx 2.
REQ-034 SHALL cover this directed case: two vectors with masks 0x1 and 0x2 offered back-to-back, out_ready = 1 -> in_ready stays high and outputs idx 0 then idx 1 with no bubble.
REQ-035 SHALL cover this directed case: mask = 0x3, out_ready low for 3 cycles -> idx 0 and its data held stable for 3 cycles and in_ready = 0.
REQ-036 SHALL cover this directed case: mask = 0 with in_last = 1 -> accepted in one cycle, out_valid never asserts.
REQ-037 SHALL cover this directed case: mask = all-ones (62 bits), rst asserted after 10 pops -> out_valid = 0 the next cycle and in_ready = 1 one cycle after rst deasserts.
REQ-038 SHALL cover this directed case, with FAN_COLLECT_PERF_EN defined: REQ-035 stimulus -> perf_stall_cnt = 3 and perf_emit_cnt = 2.
